// File: rtl/conv_pkg.sv
// Shared constants and FSM state encoding for the conv write-back path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

    localparam int ADDR_W = 28;
    localparam int BIAS_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_WRITE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/conv_res_fifo.sv
// Synchronous result FIFO with occupancy-derived full/empty and a head-of-queue read port.
// Latency: a push is visible at dout/empty the cycle after it is accepted.
// Backpressure: pushes while full and pops while empty are dropped; flush empties it at the next edge.
//
// Ports: clk/rst_n; flush (sync clear); push/din; pop; dout (head); full; empty.
module conv_res_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: contents are only observed behind a non-empty count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/conv_wr_ctrl.sv
// Conv result write-back: buffers result words, fetches one address per word, writes it to memory.
// Latency: 4 cycles from the push cycle to mem_wr_en when the address arrives right after the request.
// Backpressure: res_rdy drops when the FIFO is full; a write holds in WRITE until mem_wr_rdy.
//
// Ports: clk/rst_n; conv_start (low = flush); res_vld/res_data/res_rdy (result in);
//        CwbCc_addrRq / CcCwb_primAddr* (address handshake); mem_wr_* (memory write);
//        wr_cnt (accepted writes), wr_err (sticky address timeout).
module conv_wr_ctrl
    import conv_pkg::*;
#(
    parameter int word_len   = 32,
    parameter int fifo_depth = 4,
    parameter int tmo_cycles = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                conv_start,
    input  logic                res_vld,
    input  logic [word_len-1:0] res_data,
    output logic                res_rdy,
    output logic                CwbCc_addrRq,
    input  logic [ADDR_W-1:0]   CcCwb_primAddr,
    input  logic                CcCwb_primAddrEn,
    input  logic [BIAS_W-1:0]   CcCwb_primAddrBias,
    output logic                mem_wr_en,
    output logic [ADDR_W-1:0]   mem_wr_addr,
    output logic [word_len-1:0] mem_wr_data,
    input  logic                mem_wr_rdy,
    output logic [15:0]         wr_cnt,
    output logic                wr_err
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BIAS_W-1:0]   bias_q, bias_d;
    logic [7:0]          tmo_q, tmo_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                err_q, err_d;

    logic                fifo_full;
    logic                fifo_empty;
    logic [word_len-1:0] fifo_head;
    logic                push;
    logic                wr_fire;

    assign res_rdy = !fifo_full;
    assign push    = res_vld && res_rdy && conv_start;
    assign wr_fire = (state_q == ST_WRITE) && mem_wr_rdy;

    conv_res_fifo #(
        .WIDTH (word_len),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (!conv_start),
        .push  (push),
        .din   (res_data),
        .pop   (wr_fire),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        bias_d  = bias_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        // A write accepted on the flush cycle still happened, so it is counted.
        if (wr_fire) cnt_d = cnt_q + 16'd1;

        if (!conv_start) begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:  if (!fifo_empty) state_d = ST_REQ;
                // primAddrEn is a level that may be left high; it is only sampled in WAIT.
                ST_REQ: begin
                    state_d = ST_WAIT;
                    tmo_d   = 8'd0;
                end
                ST_WAIT: begin
                    if (CcCwb_primAddrEn) begin
                        addr_d  = CcCwb_primAddr;
                        bias_d  = CcCwb_primAddrBias;
                        state_d = ST_WRITE;
                    end else if (tmo_q == 8'(tmo_cycles - 1)) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
                ST_WRITE: if (mem_wr_rdy) state_d = ST_IDLE;
                ST_ERR:   state_d = ST_ERR;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            bias_q  <= '0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bias_q  <= bias_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Write outputs are gated to WRITE so they read zero in reset and while idle;
    // inside WRITE they are stable because the latched address and FIFO head only move on a pop.
    assign CwbCc_addrRq = (state_q == ST_REQ);
    assign mem_wr_en    = (state_q == ST_WRITE);
    assign mem_wr_addr  = mem_wr_en ? (addr_q + ADDR_W'(bias_q)) : '0;
    assign mem_wr_data  = mem_wr_en ? fifo_head : '0;
    assign wr_cnt       = cnt_q;
    assign wr_err       = err_q;

endmodule

// File: tb/tb_conv_wr_ctrl.sv
// Directed bench for conv_wr_ctrl with hand-computed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_conv_wr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        conv_start;
    logic        res_vld;
    logic [31:0] res_data;
    logic        res_rdy;
    logic        CwbCc_addrRq;
    logic [27:0] CcCwb_primAddr;
    logic        CcCwb_primAddrEn;
    logic [5:0]  CcCwb_primAddrBias;
    logic        mem_wr_en;
    logic [27:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_rdy;
    logic [15:0] wr_cnt;
    logic        wr_err;

    int n_chk  = 0;
    int n_err  = 0;
    int rq_cnt = 0;
    int wr_seen = 0;
    int served = 0;
    int b_rq;
    int b_wr;

    logic [31:0] words [5];

    conv_wr_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .conv_start         (conv_start),
        .res_vld            (res_vld),
        .res_data           (res_data),
        .res_rdy            (res_rdy),
        .CwbCc_addrRq       (CwbCc_addrRq),
        .CcCwb_primAddr     (CcCwb_primAddr),
        .CcCwb_primAddrEn   (CcCwb_primAddrEn),
        .CcCwb_primAddrBias (CcCwb_primAddrBias),
        .mem_wr_en          (mem_wr_en),
        .mem_wr_addr        (mem_wr_addr),
        .mem_wr_data        (mem_wr_data),
        .mem_wr_rdy         (mem_wr_rdy),
        .wr_cnt             (wr_cnt),
        .wr_err             (wr_err)
    );

    always #5 clk = ~clk;

    // Event monitors: address-request pulses and accepted writes.
    always @(posedge clk) begin
        if (CwbCc_addrRq) rq_cnt <= rq_cnt + 1;
        if (mem_wr_en && mem_wr_rdy) wr_seen <= wr_seen + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] d);
        res_vld  = 1'b1;
        res_data = d;
        tick();
        res_vld  = 1'b0;
    endtask

    // Wait for the next request pulse, answer in WAIT, check the write, optionally accept it.
    task automatic serve(input logic [27:0] a, input logic [5:0] b,
                         input logic [27:0] exp_a, input logic [31:0] exp_d, input bit accept);
        int n = 0;
        while (!((rq_cnt > served) && !CwbCc_addrRq) && n < 400) begin
            tick();
            n++;
        end
        chk("rq_seen", 64'(rq_cnt > served), 64'd1);
        CcCwb_primAddr     = a;
        CcCwb_primAddrBias = b;
        CcCwb_primAddrEn   = 1'b1;
        tick();
        CcCwb_primAddrEn   = 1'b0;
        chk("wr_en", 64'(mem_wr_en), 64'd1);
        chk("wr_addr", 64'(mem_wr_addr), 64'(exp_a));
        chk("wr_data", 64'(mem_wr_data), 64'(exp_d));
        served = served + 1;
        if (accept) begin
            mem_wr_rdy = 1'b1;
            tick();
            mem_wr_rdy = 1'b0;
            chk("wr_done_en", 64'(mem_wr_en), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; conv_start = 1'b0; res_vld = 1'b0; res_data = '0;
        CcCwb_primAddr = '0; CcCwb_primAddrEn = 1'b0; CcCwb_primAddrBias = '0;
        mem_wr_rdy = 1'b0;
        words[0] = 32'h1111_0000; words[1] = 32'h2222_0001; words[2] = 32'h3333_0002;
        words[3] = 32'h4444_0003; words[4] = 32'h5555_0004;
        tick(); tick();

        // Reset values
        chk("rst_rdy",   64'(res_rdy), 64'd1);
        chk("rst_rq",    64'(CwbCc_addrRq), 64'd0);
        chk("rst_en",    64'(mem_wr_en), 64'd0);
        chk("rst_addr",  64'(mem_wr_addr), 64'd0);
        chk("rst_data",  64'(mem_wr_data), 64'd0);
        chk("rst_cnt",   64'(wr_cnt), 64'd0);
        chk("rst_err",   64'(wr_err), 64'd0);
        rst_n = 1'b1;
        conv_start = 1'b1;
        tick();

        // Single word, exact latency: push edge, IDLE, REQ, WAIT, then WRITE.
        push_one(32'hDEAD_BEEF);
        chk("t1_en_idle", 64'(mem_wr_en), 64'd0);
        tick();
        chk("t1_rq_hi", 64'(CwbCc_addrRq), 64'd1);
        chk("t1_en_req", 64'(mem_wr_en), 64'd0);
        tick();
        chk("t1_rq_lo", 64'(CwbCc_addrRq), 64'd0);
        CcCwb_primAddr = 28'h000_1000; CcCwb_primAddrBias = 6'd5; CcCwb_primAddrEn = 1'b1;
        tick();
        CcCwb_primAddrEn = 1'b0;
        chk("t1_en", 64'(mem_wr_en), 64'd1);
        chk("t1_addr", 64'(mem_wr_addr), 64'h000_1005);
        chk("t1_data", 64'(mem_wr_data), 64'hDEAD_BEEF);
        tick();
        chk("t1_hold_en", 64'(mem_wr_en), 64'd1);
        chk("t1_hold_addr", 64'(mem_wr_addr), 64'h000_1005);
        chk("t1_hold_data", 64'(mem_wr_data), 64'hDEAD_BEEF);
        mem_wr_rdy = 1'b1;
        tick();
        mem_wr_rdy = 1'b0;
        chk("t1_en_done", 64'(mem_wr_en), 64'd0);
        chk("t1_cnt", 64'(wr_cnt), 64'd1);
        tick();

        // Fill to full with writes stalled, fifth word blocked, then in-order drain.
        served = rq_cnt;
        for (int i = 0; i < 4; i++) begin
            res_vld = 1'b1;
            res_data = words[i];
            chk("t2_rdy_fill", 64'(res_rdy), 64'd1);
            tick();
        end
        chk("t2_rdy_full", 64'(res_rdy), 64'd0);
        res_data = words[4];
        tick(); tick();
        chk("t2_rdy_still_full", 64'(res_rdy), 64'd0);
        serve(28'h000_2000, 6'd0, 28'h000_2000, words[0], 1'b1);
        chk("t2_rdy_after_pop", 64'(res_rdy), 64'd1);
        tick();
        res_vld = 1'b0;
        for (int i = 1; i < 5; i++) begin
            serve(28'h000_2000 + 28'(i), 6'd1, 28'h000_2001 + 28'(i), words[i], 1'b1);
        end
        chk("t2_cnt", 64'(wr_cnt), 64'd6);
        tick();

        // primAddrEn held high: one request and one write per word.
        b_rq = rq_cnt; b_wr = wr_seen;
        CcCwb_primAddr = 28'h000_0100; CcCwb_primAddrBias = 6'd0; CcCwb_primAddrEn = 1'b1;
        mem_wr_rdy = 1'b1;
        res_vld = 1'b1; res_data = 32'hA5A5_0001;
        tick();
        res_data = 32'hA5A5_0002;
        tick();
        res_vld = 1'b0;
        repeat (12) tick();
        chk("t3_rq_pulses", 64'(rq_cnt - b_rq), 64'd2);
        chk("t3_writes", 64'(wr_seen - b_wr), 64'd2);
        chk("t3_cnt", 64'(wr_cnt), 64'd8);
        CcCwb_primAddrEn = 1'b0; mem_wr_rdy = 1'b0;
        tick();

        // Address wrap modulo 2^28.
        served = rq_cnt;
        push_one(32'h1234_5678);
        serve(28'hFFF_FFFF, 6'd3, 28'h000_0002, 32'h1234_5678, 1'b1);
        chk("t4_cnt", 64'(wr_cnt), 64'd9);
        tick();

        // Address never arrives: timeout after 255 WAIT cycles, then flush.
        push_one(32'hCAFE_F00D);
        repeat (256) tick();
        chk("t5_err_before", 64'(wr_err), 64'd0);
        tick();
        chk("t5_err_set", 64'(wr_err), 64'd1);
        chk("t5_en_err", 64'(mem_wr_en), 64'd0);
        repeat (5) tick();
        chk("t5_err_sticky", 64'(wr_err), 64'd1);
        conv_start = 1'b0;
        tick();
        conv_start = 1'b1;
        chk("t5_err_clr", 64'(wr_err), 64'd0);
        chk("t5_rdy", 64'(res_rdy), 64'd1);
        chk("t5_en_flush", 64'(mem_wr_en), 64'd0);
        chk("t5_cnt_kept", 64'(wr_cnt), 64'd9);
        b_rq = rq_cnt;
        repeat (4) tick();
        chk("t5_fifo_empty", 64'(rq_cnt - b_rq), 64'd0);

        // Asynchronous reset while a write is pending.
        served = rq_cnt;
        push_one(32'hBAD0_BAD0);
        serve(28'h000_3000, 6'd2, 28'h000_3002, 32'hBAD0_BAD0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_en", 64'(mem_wr_en), 64'd0);
        chk("t6_addr", 64'(mem_wr_addr), 64'd0);
        chk("t6_data", 64'(mem_wr_data), 64'd0);
        chk("t6_cnt", 64'(wr_cnt), 64'd0);
        chk("t6_err", 64'(wr_err), 64'd0);
        chk("t6_rq", 64'(CwbCc_addrRq), 64'd0);
        chk("t6_rdy", 64'(res_rdy), 64'd1);
        tick();
        rst_n = 1'b1;
        b_rq = rq_cnt; b_wr = wr_seen;
        mem_wr_rdy = 1'b1;
        repeat (5) tick();
        mem_wr_rdy = 1'b0;
        chk("t6_discard_rq", 64'(rq_cnt - b_rq), 64'd0);
        chk("t6_discard_wr", 64'(wr_seen - b_wr), 64'd0);
        chk("t6_cnt_after", 64'(wr_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/conv_wr_ctrl.md
CONV_WR_CTRL -- requirements
Module: conv_wr_ctrl

Interface
REQ-001 Parameter word_len, default 32, SHALL set the result/memory data width in bits.
REQ-002 Parameter fifo_depth, default 4, SHALL set result FIFO depth; a power of two, at least 2.
REQ-003 Parameter tmo_cycles, default 255, SHALL set the address-wait timeout in cycles; range 1..255.
REQ-004 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset: asynchronous, active-low.
REQ-006 conv_start  in  1  convolution active; low = synchronous flush.
REQ-007 res_vld  in  1  conv unit result word valid.
REQ-008 res_data  in  word_len  result word.
REQ-009 res_rdy  out  1  SHALL be high when the FIFO is not full.
REQ-010 CwbCc_addrRq  out  1  one-cycle address request to the conv controller.
REQ-011 CcCwb_primAddr  in  28  primary (pixel base) address.
REQ-012 CcCwb_primAddrEn  in  1  primary address valid (level, may stay high).
REQ-013 CcCwb_primAddrBias  in  6  filter offset within the pixel.
REQ-014 mem_wr_en  out  1  memory write request.
REQ-015 mem_wr_addr  out  28  write address.
REQ-016 mem_wr_data  out  word_len  write data.
REQ-017 mem_wr_rdy  in  1  memory accepts the write this cycle.
REQ-018 wr_cnt  out  16  count of accepted memory writes.
REQ-019 wr_err  out  1  sticky address-timeout flag.

Function
REQ-020 A result word SHALL be pushed into the FIFO on a cycle with res_vld && res_rdy && conv_start.
REQ-021 res_rdy SHALL depend only on registered FIFO occupancy; a pop on a full cycle SHALL NOT admit a push in the same cycle.
REQ-022 FSM states SHALL be IDLE, REQ, WAIT, WRITE and ERR.
REQ-023 IDLE SHALL move to REQ when the FIFO is non-empty and conv_start is high.
REQ-024 REQ SHALL assert CwbCc_addrRq for exactly one cycle, then move to WAIT.
REQ-025 WAIT SHALL latch primAddr and bias when CcCwb_primAddrEn is high, then move to WRITE; a primAddrEn level seen during REQ SHALL be ignored.
REQ-026 In WRITE: mem_wr_addr = primAddr + zero-extended bias, modulo 2^28; mem_wr_data = FIFO head.
REQ-027 mem_wr_en, mem_wr_addr and mem_wr_data SHALL stay stable in WRITE until mem_wr_rdy is high.
REQ-028 On mem_wr_en && mem_wr_rdy the FSM SHALL pop the FIFO, increment wr_cnt (wrapping at 0xFFFF) and return to IDLE.
REQ-029 Each result word SHALL get exactly one address request.
REQ-030 Minimum latency from the push cycle to mem_wr_en high SHALL be 4 cycles, given primAddrEn high in the cycle after CwbCc_addrRq.
REQ-031 If WAIT lasts tmo_cycles cycles without primAddrEn, the FSM SHALL enter ERR, set wr_err and hold mem_wr_en low.
REQ-032 ERR SHALL be left only by reset or by conv_start low.
REQ-033 conv_start low SHALL, at the next edge, empty the FIFO, force IDLE, drop mem_wr_en and clear wr_err.
REQ-034 conv_start low SHALL preserve wr_cnt.
REQ-035 Push and pop in the same cycle on a non-full FIFO SHALL both take effect, leaving occupancy unchanged.

Reset
REQ-036 On rst_n low all of the following SHALL clear asynchronously:
- FSM to IDLE; FIFO empty, so res_rdy=1;
- CwbCc_addrRq=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0;
- wr_cnt=0, wr_err=0; latched address and bias = 0.
REQ-037 Reset asserted mid-write SHALL discard the pending word with no completed write.

Structure
REQ-038 A shared package conv_pkg SHALL hold ADDR_W=28, BIAS_W=6 and the FSM state enum.
REQ-039 The FIFO SHALL be a separate sub-module conv_res_fifo (sync, parameterised width/depth, with full and empty outputs).

Verification
REQ-040 Push 0xDEADBEEF; controller answers primAddr=0x0001000, bias=5, one cycle after request -> mem_wr_en 4 cycles after push, addr 0x0001005, data 0xDEADBEEF, wr_cnt=1.
REQ-041 Push 5 words, mem_wr_rdy held low -> res_rdy low after the 4th word; writes drain in order once mem_wr_rdy rises.
REQ-042 primAddrEn held high permanently -> exactly one CwbCc_addrRq pulse per word and no duplicate writes.
REQ-043 primAddr=0xFFFFFFF, bias=3 -> mem_wr_addr=0x0000002.
REQ-044 primAddrEn never asserted -> wr_err=1 after 255 WAIT cycles; conv_start low for one cycle -> IDLE, wr_err=0, FIFO empty.
REQ-045 rst_n pulsed low during WRITE -> all outputs at reset values at once; wr_cnt=0.
